alu_operand_stage: RTL and testbench

Execute-stage operand register that sits directly upstream of the ALU adder and drives its opd1, opd2 and alu_op_select inputs. It accepts decoded instructions over a valid/ready handshake and holds them in a 2-entry skid buffer. Before presenting operands, it selects the immediate or rs2 and applies result forwarding from the adder's own writeback bus.

---
 rtl/alu_pkg.sv | 27 ++
 rtl/alu_operand_stage_if.sv | 58 +++++
 rtl/alu_fwd_mux.sv | 38 +++
 rtl/alu_operand_stage.sv | 251 +++++++++++++++++++++++++
 tb/tb_alu_operand_stage.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_pkg
// Purpose  : Shared constants for the ALU operand stage: ALU operation
//            codes, operand-stage state encoding and default widths.
// Ports    : none (package)
// Options  : none
// Revision : 1.0 - initial release
// ============================================================================
package alu_pkg;

  // Default datapath widths
  localparam int DEFAULT_OPERAND_LENGTH = 32;
  localparam int DEFAULT_REG_ADDR_WIDTH = 5;

  // ALU operation codes understood by the downstream adder
  localparam logic [2:0] ALU_OP_ADD = 3'd0;
  localparam logic [2:0] ALU_OP_SUB = 3'd1;

  // Operand-stage occupancy states
  typedef logic [1:0] stage_state_t;
  localparam stage_state_t EMPTY = 2'd0;
  localparam stage_state_t ONE   = 2'd1;
  localparam stage_state_t FULL  = 2'd2;

endpackage
`default_nettype wire

// File: rtl/alu_operand_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_operand_stage_if
// Purpose  : Bundles the decode-side handshake, the forwarding bus and the
//            ALU-side handshake of the operand stage.
// Ports    : master - environment view (decode, writeback, ALU)
//            slave  - operand-stage view
// Options  : none
// Revision : 1.0 - initial release
// ============================================================================
interface alu_operand_stage_if
  import alu_pkg::*;
#(
  parameter int OPERAND_LENGTH = DEFAULT_OPERAND_LENGTH,
  parameter int REG_ADDR_WIDTH = DEFAULT_REG_ADDR_WIDTH
);

  // Decode side
  logic                      in_valid;
  logic                      in_ready;
  logic [OPERAND_LENGTH-1:0] in_rs1_data;
  logic [OPERAND_LENGTH-1:0] in_rs2_data;
  logic [OPERAND_LENGTH-1:0] in_imm;
  logic                      in_use_imm;
  logic [REG_ADDR_WIDTH-1:0] in_rs1_addr;
  logic [REG_ADDR_WIDTH-1:0] in_rs2_addr;
  logic [REG_ADDR_WIDTH-1:0] in_rd_addr;
  logic [2:0]                in_alu_op_select;

  // Forwarding bus from the adder writeback
  logic                      fwd_valid;
  logic [REG_ADDR_WIDTH-1:0] fwd_rd_addr;
  logic [OPERAND_LENGTH-1:0] fwd_data;

  // ALU side
  logic                      out_valid;
  logic                      out_ready;
  logic [OPERAND_LENGTH-1:0] opd1;
  logic [OPERAND_LENGTH-1:0] opd2;
  logic [2:0]                alu_op_select;
  logic [REG_ADDR_WIDTH-1:0] out_rd_addr;

  modport master (
    output in_valid, in_rs1_data, in_rs2_data, in_imm, in_use_imm,
           in_rs1_addr, in_rs2_addr, in_rd_addr, in_alu_op_select,
           fwd_valid, fwd_rd_addr, fwd_data, out_ready,
    input  in_ready, out_valid, opd1, opd2, alu_op_select, out_rd_addr
  );

  modport slave (
    input  in_valid, in_rs1_data, in_rs2_data, in_imm, in_use_imm,
           in_rs1_addr, in_rs2_addr, in_rd_addr, in_alu_op_select,
           fwd_valid, fwd_rd_addr, fwd_data, out_ready,
    output in_ready, out_valid, opd1, opd2, alu_op_select, out_rd_addr
  );

endinterface
`default_nettype wire

// File: rtl/alu_fwd_mux.sv
`default_nettype none
// ============================================================================
// Module   : alu_fwd_mux
// Purpose  : Forwarding select for one operand. Replaces the held value with
//            the forwarded result when the forwarding bus is valid, targets a
//            non-zero register and matches the operand's source address.
// Ports    : i_en          - operand may be forwarded (e.g. not an immediate)
//            i_addr        - source register address of the operand
//            i_fwd_valid   - forwarding bus carries a result
//            i_fwd_rd_addr - destination of the forwarded result
//            i_fwd_data    - forwarded result
//            i_held        - current operand value
//            o_data        - selected operand value
// Options  : none
// Revision : 1.0 - initial release
// ============================================================================
module alu_fwd_mux #(
  parameter int OPERAND_LENGTH = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      i_en,
  input  logic [REG_ADDR_WIDTH-1:0] i_addr,
  input  logic                      i_fwd_valid,
  input  logic [REG_ADDR_WIDTH-1:0] i_fwd_rd_addr,
  input  logic [OPERAND_LENGTH-1:0] i_fwd_data,
  input  logic [OPERAND_LENGTH-1:0] i_held,
  output logic [OPERAND_LENGTH-1:0] o_data
);

  logic w_hit;

  // x0 is hard-wired zero, so a result "written" to it must never propagate
  assign w_hit  = i_en && i_fwd_valid && (i_fwd_rd_addr != '0) &&
                  (i_fwd_rd_addr == i_addr);
  assign o_data = w_hit ? i_fwd_data : i_held;

endmodule
`default_nettype wire

// File: rtl/alu_operand_stage.sv
`default_nettype none
// ============================================================================
// Module   : alu_operand_stage
// Purpose  : Execute-stage operand register in front of the ALU adder. Holds
//            up to two decoded instructions (main + skid) in FIFO order, picks
//            immediate or rs2 for operand 2 and optionally applies result
//            forwarding at capture and while entries are held.
// Ports    : clk   - clock, rising edge
//            rst_n - asynchronous active-low reset
//            bus   - alu_operand_stage_if.slave (decode handshake, forwarding
//                    bus, ALU handshake and operands)
// Options  : ALU_OPERAND_FWD_EN - when defined, forwarding is applied at
//            capture and held entries snoop the forwarding bus every clock.
// Revision : 1.0 - initial release
// ============================================================================
module alu_operand_stage
  import alu_pkg::*;
#(
  parameter int OPERAND_LENGTH = DEFAULT_OPERAND_LENGTH,
  parameter int REG_ADDR_WIDTH = DEFAULT_REG_ADDR_WIDTH
) (
  input logic                clk,
  input logic                rst_n,
  alu_operand_stage_if.slave bus
);

`ifdef ALU_OPERAND_FWD_EN
  localparam logic c_fwd_en = 1'b1;
`else
  localparam logic c_fwd_en = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // State and handshake
  // --------------------------------------------------------------------------
  stage_state_t r_state;
  stage_state_t w_state_nxt;
  logic         r_in_ready;
  logic         w_in_fire;
  logic         w_out_fire;
  logic         w_load_main_in;
  logic         w_load_main_skid;
  logic         w_load_skid;

  // Entry storage
  logic [OPERAND_LENGTH-1:0] r_main_op1, r_main_op2, r_skid_op1, r_skid_op2;
  logic [2:0]                r_main_op, r_skid_op;
  logic [REG_ADDR_WIDTH-1:0] r_main_rd, r_skid_rd;

  // Captured operands and snooped versions of held operands
  logic [OPERAND_LENGTH-1:0] w_cap_op1, w_cap_op2, w_raw_op2;
  logic [OPERAND_LENGTH-1:0] w_main_op1_snp, w_main_op2_snp;
  logic [OPERAND_LENGTH-1:0] w_skid_op1_snp, w_skid_op2_snp;

  assign w_in_fire  = bus.in_valid && r_in_ready;
  assign w_out_fire = bus.out_valid && bus.out_ready;

  // ready is registered so out_ready never reaches in_ready combinationally
  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = (r_state != EMPTY);

  always_comb begin
    w_state_nxt      = r_state;
    w_load_main_in   = 1'b0;
    w_load_main_skid = 1'b0;
    w_load_skid      = 1'b0;
    case (r_state)
      EMPTY: begin
        if (w_in_fire) begin
          w_state_nxt    = ONE;
          w_load_main_in = 1'b1;
        end
      end
      ONE: begin
        if (w_in_fire && !w_out_fire) begin
          w_state_nxt = FULL;
          w_load_skid = 1'b1;
        end else if (!w_in_fire && w_out_fire) begin
          w_state_nxt = EMPTY;
        end else if (w_in_fire && w_out_fire) begin
          w_load_main_in = 1'b1;
        end
      end
      FULL: begin
        if (w_out_fire) begin
          w_state_nxt      = ONE;
          w_load_main_skid = 1'b1;
        end
      end
      default: w_state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= EMPTY;
      r_in_ready <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_in_ready <= (w_state_nxt != FULL);
    end
  end

  // --------------------------------------------------------------------------
  // Operand capture
  // --------------------------------------------------------------------------
  assign w_raw_op2 = bus.in_use_imm ? bus.in_imm : bus.in_rs2_data;

  alu_fwd_mux #(
    .OPERAND_LENGTH(OPERAND_LENGTH),
    .REG_ADDR_WIDTH(REG_ADDR_WIDTH)
  ) u_cap_rs1 (
    .i_en          (c_fwd_en),
    .i_addr        (bus.in_rs1_addr),
    .i_fwd_valid   (bus.fwd_valid),
    .i_fwd_rd_addr (bus.fwd_rd_addr),
    .i_fwd_data    (bus.fwd_data),
    .i_held        (bus.in_rs1_data),
    .o_data        (w_cap_op1)
  );

  // An immediate is never a register value, so it is never forwarded over
  alu_fwd_mux #(
    .OPERAND_LENGTH(OPERAND_LENGTH),
    .REG_ADDR_WIDTH(REG_ADDR_WIDTH)
  ) u_cap_rs2 (
    .i_en          (c_fwd_en && !bus.in_use_imm),
    .i_addr        (bus.in_rs2_addr),
    .i_fwd_valid   (bus.fwd_valid),
    .i_fwd_rd_addr (bus.fwd_rd_addr),
    .i_fwd_data    (bus.fwd_data),
    .i_held        (w_raw_op2),
    .o_data        (w_cap_op2)
  );

  // --------------------------------------------------------------------------
  // Held-entry snooping
  // --------------------------------------------------------------------------
`ifdef ALU_OPERAND_FWD_EN
  logic [REG_ADDR_WIDTH-1:0] r_main_rs1, r_main_rs2, r_skid_rs1, r_skid_rs2;
  logic                      r_main_use_imm, r_skid_use_imm;

  // Source addresses follow their operands through main/skid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_main_rs1     <= '0;
      r_main_rs2     <= '0;
      r_main_use_imm <= 1'b0;
      r_skid_rs1     <= '0;
      r_skid_rs2     <= '0;
      r_skid_use_imm <= 1'b0;
    end else begin
      if (w_load_main_in) begin
        r_main_rs1     <= bus.in_rs1_addr;
        r_main_rs2     <= bus.in_rs2_addr;
        r_main_use_imm <= bus.in_use_imm;
      end else if (w_load_main_skid) begin
        r_main_rs1     <= r_skid_rs1;
        r_main_rs2     <= r_skid_rs2;
        r_main_use_imm <= r_skid_use_imm;
      end
      if (w_load_skid) begin
        r_skid_rs1     <= bus.in_rs1_addr;
        r_skid_rs2     <= bus.in_rs2_addr;
        r_skid_use_imm <= bus.in_use_imm;
      end
    end
  end

  alu_fwd_mux #(.OPERAND_LENGTH(OPERAND_LENGTH), .REG_ADDR_WIDTH(REG_ADDR_WIDTH))
  u_snp_main_rs1 (
    .i_en(1'b1), .i_addr(r_main_rs1), .i_fwd_valid(bus.fwd_valid),
    .i_fwd_rd_addr(bus.fwd_rd_addr), .i_fwd_data(bus.fwd_data),
    .i_held(r_main_op1), .o_data(w_main_op1_snp)
  );

  alu_fwd_mux #(.OPERAND_LENGTH(OPERAND_LENGTH), .REG_ADDR_WIDTH(REG_ADDR_WIDTH))
  u_snp_main_rs2 (
    .i_en(!r_main_use_imm), .i_addr(r_main_rs2), .i_fwd_valid(bus.fwd_valid),
    .i_fwd_rd_addr(bus.fwd_rd_addr), .i_fwd_data(bus.fwd_data),
    .i_held(r_main_op2), .o_data(w_main_op2_snp)
  );

  alu_fwd_mux #(.OPERAND_LENGTH(OPERAND_LENGTH), .REG_ADDR_WIDTH(REG_ADDR_WIDTH))
  u_snp_skid_rs1 (
    .i_en(1'b1), .i_addr(r_skid_rs1), .i_fwd_valid(bus.fwd_valid),
    .i_fwd_rd_addr(bus.fwd_rd_addr), .i_fwd_data(bus.fwd_data),
    .i_held(r_skid_op1), .o_data(w_skid_op1_snp)
  );

  alu_fwd_mux #(.OPERAND_LENGTH(OPERAND_LENGTH), .REG_ADDR_WIDTH(REG_ADDR_WIDTH))
  u_snp_skid_rs2 (
    .i_en(!r_skid_use_imm), .i_addr(r_skid_rs2), .i_fwd_valid(bus.fwd_valid),
    .i_fwd_rd_addr(bus.fwd_rd_addr), .i_fwd_data(bus.fwd_data),
    .i_held(r_skid_op2), .o_data(w_skid_op2_snp)
  );
`else
  assign w_main_op1_snp = r_main_op1;
  assign w_main_op2_snp = r_main_op2;
  assign w_skid_op1_snp = r_skid_op1;
  assign w_skid_op2_snp = r_skid_op2;
`endif

  // --------------------------------------------------------------------------
  // Entry registers. Main is always the older entry; when skid drains into
  // main it carries any forward that lands in the same cycle.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_main_op1 <= '0;
      r_main_op2 <= '0;
      r_main_op  <= '0;
      r_main_rd  <= '0;
      r_skid_op1 <= '0;
      r_skid_op2 <= '0;
      r_skid_op  <= '0;
      r_skid_rd  <= '0;
    end else begin
      if (w_load_main_in) begin
        r_main_op1 <= w_cap_op1;
        r_main_op2 <= w_cap_op2;
        r_main_op  <= bus.in_alu_op_select;
        r_main_rd  <= bus.in_rd_addr;
      end else if (w_load_main_skid) begin
        r_main_op1 <= w_skid_op1_snp;
        r_main_op2 <= w_skid_op2_snp;
        r_main_op  <= r_skid_op;
        r_main_rd  <= r_skid_rd;
      end else begin
        r_main_op1 <= w_main_op1_snp;
        r_main_op2 <= w_main_op2_snp;
      end
      if (w_load_skid) begin
        r_skid_op1 <= w_cap_op1;
        r_skid_op2 <= w_cap_op2;
        r_skid_op  <= bus.in_alu_op_select;
        r_skid_rd  <= bus.in_rd_addr;
      end else begin
        r_skid_op1 <= w_skid_op1_snp;
        r_skid_op2 <= w_skid_op2_snp;
      end
    end
  end

  assign bus.opd1          = r_main_op1;
  assign bus.opd2          = r_main_op2;
  assign bus.alu_op_select = r_main_op;
  assign bus.out_rd_addr   = r_main_rd;

endmodule
`default_nettype wire

// File: tb/tb_alu_operand_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_operand_stage
// Purpose  : Self-checking bench for alu_operand_stage: directed scenarios
//            plus randomized traffic against a queue-based reference model.
//            Forwarding scenarios are enabled with ALU_OPERAND_FWD_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_operand_stage;
  import alu_pkg::*;

  localparam int W = 32;
  localparam int A = 5;

  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_pass   = 0;

  alu_operand_stage_if #(.OPERAND_LENGTH(W), .REG_ADDR_WIDTH(A)) bus ();

  alu_operand_stage #(.OPERAND_LENGTH(W), .REG_ADDR_WIDTH(A)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1);
  end

  // Reference model: an ordered list of pending instructions
  typedef struct {
    logic [W-1:0] op1;
    logic [W-1:0] op2;
    logic [2:0]   op;
    logic [A-1:0] rd;
    logic [A-1:0] rs1a;
    logic [A-1:0] rs2a;
    logic         use_imm;
  } ent_t;

  ent_t q[$];

  function automatic logic [W-1:0] fwd_val(input logic [A-1:0] addr, input logic [W-1:0] v);
`ifdef ALU_OPERAND_FWD_EN
    if (bus.fwd_valid && bus.fwd_rd_addr != 0 && bus.fwd_rd_addr == addr) return bus.fwd_data;
`endif
    return v;
  endfunction

  // One clock of the reference model, evaluated on the inputs about to be sampled
  task automatic model_step();
    bit   in_fire, out_fire;
    ent_t e;
    in_fire  = bus.in_valid && (q.size() < 2);
    out_fire = (q.size() > 0) && bus.out_ready;
    for (int i = 0; i < q.size(); i++) begin
      e = q[i];
      e.op1 = fwd_val(e.rs1a, e.op1);
      if (!e.use_imm) e.op2 = fwd_val(e.rs2a, e.op2);
      q[i] = e;
    end
    if (out_fire) void'(q.pop_front());
    if (in_fire) begin
      e.rs1a = bus.in_rs1_addr;
      e.rs2a = bus.in_rs2_addr;
      e.use_imm = bus.in_use_imm;
      e.op  = bus.in_alu_op_select;
      e.rd  = bus.in_rd_addr;
      e.op1 = fwd_val(bus.in_rs1_addr, bus.in_rs1_data);
      e.op2 = bus.in_use_imm ? bus.in_imm : fwd_val(bus.in_rs2_addr, bus.in_rs2_data);
      q.push_back(e);
    end
  endtask

  task automatic idle_inputs();
    bus.in_valid = 0; bus.in_rs1_data = 0; bus.in_rs2_data = 0; bus.in_imm = 0;
    bus.in_use_imm = 0; bus.in_rs1_addr = 0; bus.in_rs2_addr = 0; bus.in_rd_addr = 0;
    bus.in_alu_op_select = 0; bus.fwd_valid = 0; bus.fwd_rd_addr = 0; bus.fwd_data = 0;
    bus.out_ready = 0;
  endtask

  task automatic drive_in(input logic [W-1:0] r1, input logic [W-1:0] r2, input logic [A-1:0] a1,
                          input logic [A-1:0] a2, input logic [2:0] op, input logic [A-1:0] rd);
    bus.in_valid = 1; bus.in_rs1_data = r1; bus.in_rs2_data = r2; bus.in_rs1_addr = a1;
    bus.in_rs2_addr = a2; bus.in_alu_op_select = op; bus.in_rd_addr = rd; bus.in_use_imm = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 0;
    tick(); tick();
    n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid: got %0b want 0", bus.out_valid); else n_pass++;
    n_checks++; if (bus.in_ready !== 1'b0) $display("FAIL reset_in_ready: got %0b want 0", bus.in_ready); else n_pass++;
    n_checks++; if ({bus.opd1, bus.opd2, bus.alu_op_select, bus.out_rd_addr} !== '0)
      $display("FAIL reset_outputs: got %h/%h/%h/%h want all 0", bus.opd1, bus.opd2, bus.alu_op_select, bus.out_rd_addr); else n_pass++;
    rst_n = 1;
    tick();
    n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL reset_release_ready: got %0b want 1", bus.in_ready); else n_pass++;
  endtask

  task automatic test_basic();
    bus.out_ready = 1;
    drive_in(32'd6, 32'd3, 5'd1, 5'd2, ALU_OP_SUB, 5'd3);
    tick();
    bus.in_valid = 0;
    n_checks++; if (bus.out_valid !== 1'b1) $display("FAIL basic_valid: got %0b want 1", bus.out_valid); else n_pass++;
    n_checks++; if (bus.opd1 !== 32'd6 || bus.opd2 !== 32'd3)
      $display("FAIL basic_opd: got %0d/%0d want 6/3", bus.opd1, bus.opd2); else n_pass++;
    n_checks++; if (bus.alu_op_select !== 3'd1 || bus.out_rd_addr !== 5'd3)
      $display("FAIL basic_op_rd: got %0d/%0d want 1/3", bus.alu_op_select, bus.out_rd_addr); else n_pass++;
    tick();
    n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL basic_drain: got %0b want 0", bus.out_valid); else n_pass++;
  endtask

  task automatic test_back_to_back();
    bus.out_ready = 0;
    drive_in(32'd1, 32'd5, 5'd1, 5'd2, 3'd0, 5'd10);
    n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL b2b_ready_a: got %0b want 1", bus.in_ready); else n_pass++;
    tick();
    drive_in(32'd6, 32'd4, 5'd1, 5'd2, 3'd1, 5'd11);
    n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL b2b_ready_b: got %0b want 1", bus.in_ready); else n_pass++;
    tick();
    drive_in(32'd6, 32'd7, 5'd1, 5'd2, 3'd2, 5'd12);
    n_checks++; if (bus.in_ready !== 1'b0) $display("FAIL b2b_ready_c: got %0b want 0", bus.in_ready); else n_pass++;
    tick();
    n_checks++; if (bus.in_ready !== 1'b0 || bus.opd1 !== 32'd1 || bus.opd2 !== 32'd5)
      $display("FAIL b2b_stall_hold: got ready=%0b %0d/%0d want ready=0 1/5", bus.in_ready, bus.opd1, bus.opd2); else n_pass++;
    bus.out_ready = 1;
    tick();
    n_checks++; if (bus.out_valid !== 1'b1 || bus.opd1 !== 32'd6 || bus.opd2 !== 32'd4 || bus.out_rd_addr !== 5'd11)
      $display("FAIL b2b_out_b: got v=%0b %0d/%0d rd=%0d want v=1 6/4 rd=11", bus.out_valid, bus.opd1, bus.opd2, bus.out_rd_addr); else n_pass++;
    tick();
    bus.in_valid = 0;
    n_checks++; if (bus.out_valid !== 1'b1 || bus.opd1 !== 32'd6 || bus.opd2 !== 32'd7 || bus.out_rd_addr !== 5'd12)
      $display("FAIL b2b_out_c: got v=%0b %0d/%0d rd=%0d want v=1 6/7 rd=12", bus.out_valid, bus.opd1, bus.opd2, bus.out_rd_addr); else n_pass++;
    tick();
    n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL b2b_empty: got %0b want 0", bus.out_valid); else n_pass++;
    bus.out_ready = 0;
  endtask

  task automatic test_imm();
    bus.out_ready = 0;
    drive_in(32'd2, 32'd9, 5'd1, 5'd2, 3'd0, 5'd4);
    bus.in_use_imm = 1; bus.in_imm = 32'hfffffffe;
    tick();
    bus.in_valid = 0; bus.in_use_imm = 0;
    n_checks++; if (bus.opd2 !== 32'hfffffffe) $display("FAIL imm_opd2: got %h want fffffffe", bus.opd2); else n_pass++;
    bus.out_ready = 1;
    tick();
    bus.out_ready = 0;
  endtask

`ifdef ALU_OPERAND_FWD_EN
  task automatic test_fwd_capture();
    bus.out_ready = 1;
    drive_in(32'd0, 32'd1, 5'd5, 5'd2, 3'd0, 5'd1);
    bus.fwd_valid = 1; bus.fwd_rd_addr = 5'd5; bus.fwd_data = 32'hffffffff;
    tick();
    bus.fwd_valid = 0; bus.in_valid = 0;
    n_checks++; if (bus.opd1 !== 32'hffffffff) $display("FAIL fwd_cap_opd1: got %h want ffffffff", bus.opd1); else n_pass++;
    tick();
    drive_in(32'd0, 32'd1, 5'd0, 5'd2, 3'd0, 5'd1);
    bus.fwd_valid = 1; bus.fwd_rd_addr = 5'd0; bus.fwd_data = 32'hffffffff;
    tick();
    bus.fwd_valid = 0; bus.in_valid = 0;
    n_checks++; if (bus.opd1 !== 32'd0) $display("FAIL fwd_cap_x0: got %h want 0", bus.opd1); else n_pass++;
    tick();
    bus.out_ready = 0;
  endtask

  task automatic test_fwd_skid();
    bus.out_ready = 0;
    drive_in(32'd10, 32'd11, 5'd2, 5'd1, 3'd0, 5'd4);
    tick();
    drive_in(32'd20, 32'd1, 5'd3, 5'd7, 3'd1, 5'd5);
    tick();
    bus.in_valid = 0;
    bus.fwd_valid = 1; bus.fwd_rd_addr = 5'd7; bus.fwd_data = 32'd42;
    tick();
    bus.fwd_valid = 0;
    bus.out_ready = 1;
    n_checks++; if (bus.opd1 !== 32'd10 || bus.opd2 !== 32'd11)
      $display("FAIL fwd_skid_main: got %0d/%0d want 10/11", bus.opd1, bus.opd2); else n_pass++;
    tick();
    n_checks++; if (bus.opd1 !== 32'd20 || bus.opd2 !== 32'd42)
      $display("FAIL fwd_skid_opd2: got %0d/%0d want 20/42", bus.opd1, bus.opd2); else n_pass++;
    tick();
    bus.out_ready = 0;
  endtask
`endif

  task automatic test_reset_full();
    bus.out_ready = 0;
    drive_in(32'd100, 32'd200, 5'd1, 5'd2, 3'd3, 5'd6);
    tick();
    drive_in(32'd300, 32'd400, 5'd1, 5'd2, 3'd4, 5'd7);
    tick();
    bus.in_valid = 0;
    #2 rst_n = 0;
    #1;
    n_checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0)
      $display("FAIL rstfull_flags: got v=%0b r=%0b want 0/0", bus.out_valid, bus.in_ready); else n_pass++;
    n_checks++; if ({bus.opd1, bus.opd2, bus.alu_op_select, bus.out_rd_addr} !== '0)
      $display("FAIL rstfull_outputs: got %h/%h/%h/%h want all 0", bus.opd1, bus.opd2, bus.alu_op_select, bus.out_rd_addr); else n_pass++;
    tick();
    rst_n = 1;
    tick();
    n_checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0)
      $display("FAIL rstfull_release: got r=%0b v=%0b want 1/0", bus.in_ready, bus.out_valid); else n_pass++;
    bus.out_ready = 1;
    tick();
    n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL rstfull_stale: got %0b want 0", bus.out_valid); else n_pass++;
    bus.out_ready = 0;
  endtask

  task automatic test_random();
    idle_inputs();
    rst_n = 0;
    tick();
    rst_n = 1;
    tick();
    q.delete();
    for (int cyc = 0; cyc < 400; cyc++) begin
      n_checks++; if (bus.in_ready !== (q.size() < 2))
        $display("FAIL rand_ready cyc %0d: got %0b want %0b", cyc, bus.in_ready, q.size() < 2); else n_pass++;
      n_checks++; if (bus.out_valid !== (q.size() > 0))
        $display("FAIL rand_valid cyc %0d: got %0b want %0b", cyc, bus.out_valid, q.size() > 0); else n_pass++;
      if (q.size() > 0) begin
        n_checks++;
        if (bus.opd1 !== q[0].op1 || bus.opd2 !== q[0].op2 || bus.alu_op_select !== q[0].op || bus.out_rd_addr !== q[0].rd)
          $display("FAIL rand_data cyc %0d: got %h/%h/%0d/%0d want %h/%h/%0d/%0d", cyc, bus.opd1, bus.opd2,
                   bus.alu_op_select, bus.out_rd_addr, q[0].op1, q[0].op2, q[0].op, q[0].rd);
        else n_pass++;
      end
      bus.in_valid = ($urandom_range(0, 3) != 0);
      bus.in_rs1_data = $urandom; bus.in_rs2_data = $urandom; bus.in_imm = $urandom;
      bus.in_use_imm = $urandom_range(0, 1);
      bus.in_rs1_addr = 5'($urandom_range(0, 3)); bus.in_rs2_addr = 5'($urandom_range(0, 3));
      bus.in_rd_addr = 5'($urandom_range(0, 31)); bus.in_alu_op_select = 3'($urandom_range(0, 7));
      bus.fwd_valid = $urandom_range(0, 1); bus.fwd_rd_addr = 5'($urandom_range(0, 3));
      bus.fwd_data = $urandom;
      bus.out_ready = ($urandom_range(0, 9) < 6);
      model_step();
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_imm();
`ifdef ALU_OPERAND_FWD_EN
    test_fwd_capture();
    test_fwd_skid();
`endif
    test_reset_full();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
